// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default widths for the mem_responder slice
package mem_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 9;
    localparam int DEF_WAIT_STATES = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE,
        ST_HOLD
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM, registered read, write enable
module mem_array #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR memory responder with wait states and mfc handshake
// Optional feature: MEM_PARITY_EN adds an even-parity bit per RAM word and a sticky parity_err.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] MDRout,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mfc,
    output logic                  busy,
    output logic                  addr_err,
    output logic                  req_err,
    output logic                  parity_err
);

`ifdef MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int RAM_W = DATA_WIDTH + PAR_W;
    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES - 1);

    state_t                  state;
    op_t                     op_q;
    logic [31:0]             addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              wcnt;
    logic                    oor;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [RAM_W-1:0]        ram_wdata;
    logic [RAM_W-1:0]        ram_rdata;

    assign oor    = |addr_q[31:ADDR_WIDTH];
    assign busy   = (state != ST_IDLE);
    assign ram_we = (state == ST_ACCESS) && (op_q == OP_WRITE) && !oor;

    // The RAM reads every cycle; presenting the live address in IDLE lets a
    // zero-wait read have its data ready by the time ACCESS ends.
    assign ram_addr = (state == ST_IDLE) ? address[ADDR_WIDTH-1:0] : addr_q[ADDR_WIDTH-1:0];

`ifdef MEM_PARITY_EN
    logic par_q;
    assign ram_wdata = {^wdata_q, wdata_q};
`else
    assign ram_wdata  = wdata_q;
    assign parity_err = 1'b0;
`endif

    mem_array #(
        .WIDTH      (RAM_W),
        .DEPTH_LOG2 (ADDR_WIDTH)
    ) u_array (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            wcnt     <= '0;
            Mdatain  <= '0;
            mfc      <= 1'b0;
            addr_err <= 1'b0;
            req_err  <= 1'b0;
`ifdef MEM_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            mfc     <= 1'b0;
            req_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read ^ write) begin
                        addr_q  <= address;
                        wdata_q <= MDRout;
                        op_q    <= write ? OP_WRITE : OP_READ;
                        if (WAIT_STATES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            wcnt  <= WS_INIT;
                            state <= ST_WAIT;
                        end
                    end else if (read && write) begin
                        req_err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wcnt == 3'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                ST_ACCESS: begin
                    if (oor) begin
                        addr_err <= 1'b1;
                    end
                    if (op_q == OP_READ) begin
                        Mdatain <= oor ? '0 : ram_rdata[DATA_WIDTH-1:0];
`ifdef MEM_PARITY_EN
                        par_q <= ram_rdata[DATA_WIDTH];
`endif
                    end
                    mfc   <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
`ifdef MEM_PARITY_EN
                    if (op_q == OP_READ && !oor && (^{par_q, Mdatain})) begin
                        parity_err <= 1'b1;
                    end
`endif
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!read && !write) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder at one and zero wait states
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        read, write;
    logic [31:0] address, MDRout;

    logic [31:0] mdatain1, mdatain0;
    logic        mfc1, busy1, aerr1, rerr1, perr1;
    logic        mfc0, busy0, aerr0, rerr0, perr0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [512];
    int          written[$];
    logic [31:0] last_rd = 32'h0;
    logic        aerr_m  = 1'b0;

    always #5 clock = ~clock;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(1)) dut (
        .clock(clock), .clear_n(clear_n), .read(read), .write(write),
        .address(address), .MDRout(MDRout), .Mdatain(mdatain1), .mfc(mfc1),
        .busy(busy1), .addr_err(aerr1), .req_err(rerr1), .parity_err(perr1)
    );

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
        .clock(clock), .clear_n(clear_n), .read(read), .write(write),
        .address(address), .MDRout(MDRout), .Mdatain(mdatain0), .mfc(mfc0),
        .busy(busy0), .addr_err(aerr0), .req_err(rerr0), .parity_err(perr0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " Mdatain1"}, mdatain1, 32'h0);
        chk({tag, " Mdatain0"}, mdatain0, 32'h0);
        chk({tag, " flags1"}, {27'h0, mfc1, busy1, aerr1, rerr1, perr1}, 32'h0);
        chk({tag, " flags0"}, {27'h0, mfc0, busy0, aerr0, rerr0, perr0}, 32'h0);
    endtask

    // One request issued to both responders; drop_at is the cycle after
    // acceptance at which the requester lowers read/write.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int drop_at);
        int lat1, lat0, n1, n0;
        logic [31:0] d1, d0, exp;
        logic oor;
        oor = (addr[31:9] != 0);
        exp = 32'h0;
        if (wr && !oor) begin
            mem_m[addr[8:0]] = data;
            written.push_back(int'(addr[8:0]));
        end
        if (rd) begin
            exp     = oor ? 32'h0 : mem_m[addr[8:0]];
            last_rd = exp;
        end
        if (oor) aerr_m = 1'b1;
        lat1 = 0; lat0 = 0; n1 = 0; n0 = 0; d1 = 'x; d0 = 'x;
        @(negedge clock);
        read = rd; write = wr; address = addr; MDRout = data;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (mfc1) begin n1++; if (lat1 == 0) begin lat1 = k; d1 = mdatain1; end end
            if (mfc0) begin n0++; if (lat0 == 0) begin lat0 = k; d0 = mdatain0; end end
            if (k == 1) begin
                chk("busy during op", {31'h0, busy1}, 32'h1);
                address = $urandom;
                MDRout  = $urandom;
            end
            if (k == drop_at) begin
                read = 1'b0; write = 1'b0;
            end
        end
        chk("mfc latency ws1", lat1, 3);
        chk("mfc latency ws0", lat0, 2);
        chk("mfc pulses ws1", n1, 1);
        chk("mfc pulses ws0", n0, 1);
        if (rd) begin
            chk("read data ws1", d1, exp);
            chk("read data ws0", d0, exp);
        end
        chk("Mdatain held ws1", mdatain1, last_rd);
        chk("Mdatain held ws0", mdatain0, last_rd);
        chk("idle after op", {30'h0, busy1, busy0}, 32'h0);
        chk("addr_err", {30'h0, aerr1, aerr0}, {30'h0, aerr_m, aerr_m});
    endtask

    initial begin
        clear_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; MDRout = '0;
        @(negedge clock);
        chk_idle_outputs("in reset");
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        chk_idle_outputs("after reset");

        do_req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 3);
        do_req(1'b1, 1'b0, 32'd5, 32'h0, 3);
        do_req(1'b0, 1'b1, 32'h1FF, 32'h12345678, 3);
        do_req(1'b1, 1'b0, 32'h1FF, 32'h0, 3);
        do_req(1'b0, 1'b1, 32'd3, 32'h0BADF00D, 1);
        do_req(1'b1, 1'b0, 32'd3, 32'h0, 6);

        // Out-of-range traffic aliases onto word 0 only if the range check is wrong.
        do_req(1'b0, 1'b1, 32'd0, 32'h11112222, 3);
        do_req(1'b1, 1'b0, 32'h200, 32'h0, 3);
        do_req(1'b0, 1'b1, 32'h200, 32'hFFFF0000, 3);
        do_req(1'b1, 1'b0, 32'd0, 32'h0, 3);

        for (int i = 0; i < 24; i++) begin
            int r, drop;
            logic [31:0] a;
            r    = $urandom_range(0, 9);
            drop = (r % 3 == 0) ? 1 : ((r % 3 == 1) ? 3 : 6);
            if (r < 4) begin
                a = 32'($urandom_range(0, 511));
                do_req(1'b0, 1'b1, a, $urandom, drop);
            end else if (r < 8) begin
                a = 32'(written[$urandom_range(0, written.size() - 1)]);
                do_req(1'b1, 1'b0, a, $urandom, drop);
            end else begin
                a = $urandom | 32'h0000_0200;
                do_req(r[0], ~r[0], a, $urandom, drop);
            end
        end

        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 32'd5;
        @(negedge clock);
        chk("req_err pulse", {30'h0, rerr1, rerr0}, 32'h3);
        chk("no busy on req_err", {30'h0, busy1, busy0}, 32'h0);
        chk("no mfc on req_err", {30'h0, mfc1, mfc0}, 32'h0);
        read = 1'b0; write = 1'b0;
        @(negedge clock);
        chk("req_err cleared", {30'h0, rerr1, rerr0}, 32'h0);

`ifdef MEM_PARITY_EN
        do_req(1'b0, 1'b1, 32'd7, 32'hCAFEF00D, 3);
        dut.u_array.mem[7]  = dut.u_array.mem[7] ^ 33'h1;
        dut0.u_array.mem[7] = dut0.u_array.mem[7] ^ 33'h1;
        mem_m[7] = mem_m[7] ^ 32'h1;
        do_req(1'b1, 1'b0, 32'd7, 32'h0, 3);
        chk("parity_err set", {30'h0, perr1, perr0}, 32'h3);
`else
        chk("parity_err tied", {30'h0, perr1, perr0}, 32'h0);
`endif

        // Reset during WAIT of a write to word 3 must abandon the write.
        @(negedge clock);
        write = 1'b1; address = 32'd3; MDRout = 32'hA5A5A5A5;
        @(negedge clock);
        chk("in WAIT before reset", {31'h0, busy1}, 32'h1);
        clear_n = 1'b0; write = 1'b0;
        #1;
        chk_idle_outputs("mid-op reset");
        @(negedge clock);
        clear_n = 1'b1;
        aerr_m  = 1'b0;
        last_rd = 32'h0;
        do_req(1'b1, 1'b0, 32'd3, 32'h0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the mini CPU's MAR/MDR memory interface. It accepts read/write requests from the datapath, and each accepted request runs exactly one access to an internal word-addressed RAM. Reads return data on `Mdatain`, which the MDR captures. Every request, read or write, is answered with a one-cycle memory-function-complete pulse (`mfc`). Wait states are configurable so the control unit's memory-wait logic is exercised.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; matches the MDR.
- `ADDR_WIDTH`, 9: RAM index width, giving 512 words.
- `WAIT_STATES`, 1: extra cycles inserted before the RAM access; legal range 0–7.

Ports:
- `clock` in 1: single clock, rising edge.
- `clear_n` in 1: reset, asynchronous and active-low.
- `read` in 1: read request, level; held by the requester until `mfc`.
- `write` in 1: write request, level; held by the requester until `mfc`.
- `address` in 32: word address from the MAR.
- `MDRout` in DATA_WIDTH: write data from the MDR.
- `Mdatain` out DATA_WIDTH: read data to the MDR.
- `mfc` out 1: memory function complete, a one-cycle pulse.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `addr_err` out 1: sticky; set when an address is out of range.
- `req_err` out 1: one-cycle pulse when `read` and `write` are both high in IDLE.
- `parity_err` out 1: sticky; present only with `MEM_PARITY_EN`.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE, HOLD.
- IDLE, exactly one of `read`/`write` high:
  - `address` and `MDRout` are latched at that edge, along with the operation type.
  - Next state is WAIT, or ACCESS if `WAIT_STATES` = 0.
- IDLE, both `read` and `write` high:
  - `req_err` pulses, no access occurs, and the FSM stays in IDLE.
- WAIT:
  - A counter runs from `WAIT_STATES`-1 down to 0, then the FSM goes to ACCESS.
- ACCESS:
  - In-range write: the RAM is written.
  - In-range read: the RAM read is issued.
  - Out of range (latched `address[31:ADDR_WIDTH]` ≠ 0): the RAM is untouched, `addr_err` is set, and a read returns 0.
  - Next state is DONE.
- DONE:
  - `mfc` = 1.
  - For a read, `Mdatain` is loaded at the DONE-entry edge.
  - Next state is HOLD.
- HOLD:
  - Waits until `read` and `write` are both low, then returns to IDLE. Requests do not re-trigger until they are dropped.
- `Mdatain` holds its last read value. Writes and out-of-range writes do not change it.
- `addr_err` and `parity_err` are cleared only by reset.

## Timing
- Reset values: `Mdatain` = 0, `mfc` = 0, `busy` = 0, `addr_err` = 0, `req_err` = 0, `parity_err` = 0; FSM in IDLE; wait counter 0.
- RAM contents are not reset.
- Latency: `mfc` is high in cycle `WAIT_STATES` + 2 after the accepting edge.
  - With the default `WAIT_STATES` = 1, this is 3 cycles.
- `Mdatain` is valid in the same cycle as `mfc` and remains stable afterwards.
- Request inputs are sampled only in IDLE and HOLD. Changes to `address` or `MDRout` after acceptance have no effect.
- If the requester drops its request early (during WAIT or ACCESS), the access still completes and `mfc` still pulses.
- Back-to-back requests: the minimum spacing is one HOLD cycle with `read` = `write` = 0, then IDLE.
- Reset mid-operation: the FSM goes immediately to IDLE and all outputs take their reset values. An in-flight write is not performed if reset is asserted before ACCESS.

## Configuration
- `MEM_PARITY_EN` defined:
  - Each RAM word stores one extra even-parity bit, computed on write.
  - On a read, parity is checked in DONE. A mismatch sets `parity_err`, and the data is still returned.
- `MEM_PARITY_EN` undefined:
  - RAM width is DATA_WIDTH and there is no parity logic.
  - `parity_err` is tied to 0.

## Structure
- `mem_pkg` holds:
  - the FSM state enum (IDLE, WAIT, ACCESS, DONE, HOLD);
  - the default width constants;
  - the operation-type encoding.
- Sub-module `mem_array`: single-port synchronous RAM with one registered read port and a write enable. Its width is DATA_WIDTH, or DATA_WIDTH+1 with parity.

## Test plan
- Write then read: write 0xDEADBEEF to address 5. `mfc` pulses 3 cycles after acceptance. A read of address 5 returns `Mdatain` = 0xDEADBEEF in the `mfc` cycle.
- `WAIT_STATES` = 0: a read of address 0x1FF that was previously written with 0x12345678 gives `mfc` 2 cycles after acceptance with `Mdatain` = 0x12345678.
- Out of range: read address 0x200 → `mfc` pulses, `Mdatain` = 0, `addr_err` = 1 and stays set. A write to 0x200 leaves word 0 unchanged.
- Simultaneous requests: `read` = `write` = 1 in IDLE → `req_err` pulses for one cycle, there is no `mfc`, and `busy` stays 0.
- Held request and reset: keep `read` high after `mfc` → no second `mfc`. Assert `clear_n` = 0 in WAIT during a write of 0xA5A5A5A5 to address 3 → all outputs return to 0, and a subsequent read of address 3 returns the old value.
- `MEM_PARITY_EN`: force-flip one stored bit in address 7 via the bench → a read of address 7 sets `parity_err` = 1 and returns the stored data.
